fifo_level: RTL and testbench

- Parametrised synchronous FIFO, successor to the basic register-file FIFO.
- Adds an occupancy count, programmable almost-full/almost-empty thresholds, a synchronous flush, and sticky overflow/underflow error flags.
- Defines full/empty behaviour for simultaneous read+write.
- Sits between producer and consumer blocks on one clock domain; show-ahead read (head word always on r_data).

---
 rtl/fifo_level_pkg.sv | 22 ++
 rtl/fifo_regfile.sv | 31 +++
 rtl/fifo_level.sv | 102 ++++++++++
 tb/tb_fifo_level.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_level_pkg.sv
// Shared definitions for the fifo_level slice.
// Holds the default geometry and thresholds plus a legality check used at
// elaboration time by fifo_level.
package fifo_level_pkg;

  localparam int unsigned DefB        = 8;
  localparam int unsigned DefW        = 4;
  localparam int unsigned DefAeThresh = 2;
  localparam int unsigned DefAfThresh = 14;

  // Depth of a FIFO with w address bits.
  function automatic int unsigned depth_of(input int unsigned w);
    return 32'd1 << w;
  endfunction

  // Thresholds are legal when AE < depth and 0 < AF <= depth.
  function automatic bit thresh_ok(input int unsigned w, input int unsigned ae,
                                   input int unsigned af);
    return (ae < depth_of(w)) && (af != 0) && (af <= depth_of(w));
  endfunction

endpackage

// File: rtl/fifo_regfile.sv
// Storage array for fifo_level: one synchronous write port, one
// asynchronous (combinational) read port. Contents are not reset.
// Ports:
//   clk            rising-edge clock
//   w_en/w_addr/w_data  write port, stores on the clock edge when w_en=1
//   r_addr/r_data  combinational read port
module fifo_regfile
  import fifo_level_pkg::*;
#(
  parameter int unsigned B = DefB,
  parameter int unsigned W = DefW
) (
  input  logic         clk,
  input  logic         w_en,
  input  logic [W-1:0] w_addr,
  input  logic [B-1:0] w_data,
  input  logic [W-1:0] r_addr,
  output logic [B-1:0] r_data
);

  logic [B-1:0] mem [2**W];

  always_ff @(posedge clk) begin
    if (w_en) begin
      mem[w_addr] <= w_data;
    end
  end

  assign r_data = mem[r_addr];

endmodule

// File: rtl/fifo_level.sv
// Synchronous show-ahead FIFO with occupancy count, almost-empty/almost-full
// thresholds, synchronous flush and sticky overflow/underflow flags.
// Ports:
//   clk, reset_n   clock and synchronous active-low reset
//   clr            flush (pointers/count/status cleared, error flags kept)
//   rd, wr, w_data pop / push requests and push data
//   r_data         head word (valid while empty=0)
//   empty, full, almost_empty, almost_full, count  registered status
//   overflow, underflow  sticky error flags, cleared by err_clr
module fifo_level
  import fifo_level_pkg::*;
#(
  parameter int unsigned B         = DefB,
  parameter int unsigned W         = DefW,
  parameter int unsigned AE_THRESH = DefAeThresh,
  parameter int unsigned AF_THRESH = DefAfThresh
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         rd,
  input  logic         wr,
  input  logic [B-1:0] w_data,
  output logic [B-1:0] r_data,
  output logic         empty,
  output logic         full,
  output logic         almost_empty,
  output logic         almost_full,
  output logic [W:0]   count,
  output logic         overflow,
  output logic         underflow,
  input  logic         err_clr
);

  if (!thresh_ok(W, AE_THRESH, AF_THRESH)) begin : g_bad_thresh
    $error("fifo_level: illegal AE_THRESH/AF_THRESH for W");
  end

  localparam logic [W:0] DepthLvl = (W+1)'(depth_of(W));
  localparam logic [W:0] AeLvl    = (W+1)'(AE_THRESH);
  localparam logic [W:0] AfLvl    = (W+1)'(AF_THRESH);

  logic [W-1:0] w_ptr, r_ptr;
  logic         rd_acc, wr_acc;
  logic [W:0]   count_d;

  always_comb begin
    rd_acc  = rd & ~empty;
    // A read in the same cycle frees a slot, so a write at full still lands.
    wr_acc  = wr & (~full | rd_acc);
    count_d = count + (W+1)'(wr_acc) - (W+1)'(rd_acc);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      w_ptr        <= '0;
      r_ptr        <= '0;
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else if (clr) begin
      // Flush ignores rd/wr, so no new errors can arise this cycle.
      w_ptr        <= '0;
      r_ptr        <= '0;
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
      overflow     <= overflow & ~err_clr;
      underflow    <= underflow & ~err_clr;
    end else begin
      if (wr_acc) w_ptr <= w_ptr + 1'b1;
      if (rd_acc) r_ptr <= r_ptr + 1'b1;
      count        <= count_d;
      empty        <= (count_d == '0);
      full         <= (count_d == DepthLvl);
      almost_empty <= (count_d <= AeLvl);
      almost_full  <= (count_d >= AfLvl);
      // New error wins over err_clr in the same cycle.
      overflow     <= (wr & ~wr_acc) | (overflow & ~err_clr);
      underflow    <= (rd & ~rd_acc) | (underflow & ~err_clr);
    end
  end

  fifo_regfile #(
    .B (B),
    .W (W)
  ) u_regfile (
    .clk    (clk),
    .w_en   (wr_acc & reset_n & ~clr),
    .w_addr (w_ptr),
    .w_data (w_data),
    .r_addr (r_ptr),
    .r_data (r_data)
  );

endmodule

// File: tb/tb_fifo_level.sv
module tb_fifo_level;

  logic       clk = 1'b0;
  logic       reset_n, clr, rd, wr, err_clr;
  logic [7:0] w_data;
  logic [7:0] r_data;
  logic       empty, full, almost_empty, almost_full, overflow, underflow;
  logic [4:0] count;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fifo_level #(
    .B         (8),
    .W         (4),
    .AE_THRESH (2),
    .AF_THRESH (14)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .clr          (clr),
    .rd           (rd),
    .wr           (wr),
    .w_data       (w_data),
    .r_data       (r_data),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow),
    .err_clr      (err_clr)
  );

  typedef struct {
    logic       rn, cl, rd, wr;
    logic [7:0] wd;
    logic       ec;
    int         cnt;
    logic       emp, ful, ae, af, ov, un;
    logic       chk_rd;
    logic [7:0] rdv;
  } vec_t;

  vec_t tab [13];

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1ns after the edge.
  task automatic step(input logic rn, input logic cl, input logic r, input logic w,
                      input logic [7:0] wd, input logic ec);
    reset_n = rn; clr = cl; rd = r; wr = w; w_data = wd; err_clr = ec;
    @(posedge clk);
    #1;
    reset_n = 1'b1; clr = 1'b0; rd = 1'b0; wr = 1'b0; err_clr = 1'b0;
  endtask

  task automatic push(input logic [7:0] wd);
    step(1'b1, 1'b0, 1'b0, 1'b1, wd, 1'b0);
  endtask

  task automatic pop();
    step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0; clr = 1'b0; rd = 1'b0; wr = 1'b0; w_data = '0; err_clr = 1'b0;

    //          rn  cl  rd  wr  wd     ec   cnt emp ful ae af ov un chk rdv
    tab[0]  = '{1'b0,1'b0,1'b0,1'b0,8'h00,1'b0, 0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,8'h00};
    tab[1]  = '{1'b1,1'b0,1'b0,1'b0,8'h00,1'b0, 0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,8'h00};
    tab[2]  = '{1'b1,1'b0,1'b1,1'b0,8'h00,1'b0, 0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,8'h00};
    tab[3]  = '{1'b1,1'b0,1'b0,1'b0,8'h00,1'b1, 0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,8'h00};
    tab[4]  = '{1'b1,1'b0,1'b1,1'b1,8'h55,1'b0, 1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b1,8'h55};
    tab[5]  = '{1'b1,1'b0,1'b0,1'b1,8'h66,1'b0, 2,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b1,8'h55};
    tab[6]  = '{1'b1,1'b0,1'b0,1'b1,8'h77,1'b0, 3,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,8'h55};
    tab[7]  = '{1'b1,1'b0,1'b1,1'b0,8'h00,1'b0, 2,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b1,8'h66};
    tab[8]  = '{1'b1,1'b0,1'b1,1'b1,8'h88,1'b0, 2,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b1,8'h77};
    tab[9]  = '{1'b1,1'b0,1'b1,1'b0,8'h00,1'b1, 1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,8'h88};
    tab[10] = '{1'b1,1'b0,1'b1,1'b0,8'h00,1'b0, 0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,8'h00};
    tab[11] = '{1'b1,1'b0,1'b1,1'b0,8'h00,1'b1, 0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,8'h00};
    tab[12] = '{1'b1,1'b0,1'b0,1'b0,8'h00,1'b1, 0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,8'h00};

    @(posedge clk);
    #1;
    for (int i = 0; i < 13; i++) begin
      step(tab[i].rn, tab[i].cl, tab[i].rd, tab[i].wr, tab[i].wd, tab[i].ec);
      chk("tab_count", i, 32'(count), 32'(tab[i].cnt));
      chk("tab_empty", i, 32'(empty), 32'(tab[i].emp));
      chk("tab_full", i, 32'(full), 32'(tab[i].ful));
      chk("tab_aempty", i, 32'(almost_empty), 32'(tab[i].ae));
      chk("tab_afull", i, 32'(almost_full), 32'(tab[i].af));
      chk("tab_ovf", i, 32'(overflow), 32'(tab[i].ov));
      chk("tab_unf", i, 32'(underflow), 32'(tab[i].un));
      if (tab[i].chk_rd) chk("tab_rdata", i, 32'(r_data), 32'(tab[i].rdv));
    end

    // Fill 0x01..0x10 to full.
    for (int i = 0; i < 16; i++) begin
      push(8'(i + 1));
      chk("fill_count", i, 32'(count), 32'(i + 1));
      chk("fill_full", i, 32'(full), 32'(i == 15));
      chk("fill_afull", i, 32'(almost_full), 32'(i + 1 >= 14));
      chk("fill_aempty", i, 32'(almost_empty), 32'(i + 1 <= 2));
      chk("fill_rdata", i, 32'(r_data), 32'h01);
    end
    push(8'hEE);
    chk("ovf_set", 0, 32'(overflow), 32'h1);
    chk("ovf_count", 0, 32'(count), 32'd16);
    chk("ovf_rdata", 0, 32'(r_data), 32'h01);

    // Read+write at full: oldest word replaced, order preserved.
    step(1'b1, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0);
    chk("rw_full_count", 0, 32'(count), 32'd16);
    chk("rw_full_full", 0, 32'(full), 32'h1);
    chk("rw_full_rdata", 0, 32'(r_data), 32'h02);
    for (int i = 0; i < 16; i++) begin
      chk("drain_rdata", i, 32'(r_data), (i < 15) ? 32'(i + 2) : 32'h11);
      pop();
      chk("drain_count", i, 32'(count), 32'(15 - i));
    end
    chk("drain_empty", 0, 32'(empty), 32'h1);
    chk("drain_ovf_held", 0, 32'(overflow), 32'h1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("ovf_cleared", 0, 32'(overflow), 32'h0);

    // Wrap-around.
    for (int i = 0; i < 10; i++) push(8'(8'h30 + i));
    chk("wrap_count10", 0, 32'(count), 32'd10);
    for (int i = 0; i < 10; i++) begin
      chk("wrap1_rdata", i, 32'(r_data), 32'(8'h30 + i));
      pop();
    end
    for (int i = 0; i < 10; i++) push(8'(8'hA0 + i));
    for (int i = 0; i < 10; i++) begin
      chk("wrap2_rdata", i, 32'(r_data), 32'(8'hA0 + i));
      pop();
    end
    chk("wrap_count0", 0, 32'(count), 32'd0);
    chk("wrap_empty", 0, 32'(empty), 32'h1);

    // Flush with 5 words stored and overflow pending.
    for (int i = 0; i < 16; i++) push(8'(8'hC0 + i));
    push(8'hFF);
    for (int i = 0; i < 11; i++) pop();
    chk("pre_clr_count", 0, 32'(count), 32'd5);
    chk("pre_clr_ovf", 0, 32'(overflow), 32'h1);
    chk("pre_clr_rdata", 0, 32'(r_data), 32'hCB);
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("clr_count", 0, 32'(count), 32'd0);
    chk("clr_empty", 0, 32'(empty), 32'h1);
    chk("clr_aempty", 0, 32'(almost_empty), 32'h1);
    chk("clr_ovf_held", 0, 32'(overflow), 32'h1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("clr_errclr", 0, 32'(overflow), 32'h0);
    push(8'h5A);
    chk("post_clr_rdata", 0, 32'(r_data), 32'h5A);
    pop();

    // Reset mid-operation with a concurrent write.
    pop();
    chk("pre_rst_unf", 0, 32'(underflow), 32'h1);
    for (int i = 0; i < 8; i++) push(8'(8'h70 + i));
    chk("pre_rst_count", 0, 32'(count), 32'd8);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'hDD, 1'b0);
    chk("rst_count", 0, 32'(count), 32'd0);
    chk("rst_empty", 0, 32'(empty), 32'h1);
    chk("rst_ovf", 0, 32'(overflow), 32'h0);
    chk("rst_unf", 0, 32'(underflow), 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("rst_wr_dropped", 0, 32'(count), 32'd0);
    push(8'h42);
    chk("post_rst_rdata", 0, 32'(r_data), 32'h42);
    chk("post_rst_count", 0, 32'(count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
